// File: rtl/retention_power_sequencer_if.sv
// Handshake bundle between power-management logic and the retention sequencer.
// Optional pwr_good/pwr_err signals exist only when RET_PWR_GOOD_EN is defined.
interface retention_power_sequencer_if;
  logic pd_req;
  logic wake_req;
  logic save;
  logic restore;
  logic clk_en;
  logic iso_en;
  logic pwr_en;
  logic busy;
  logic domain_off;
`ifdef RET_PWR_GOOD_EN
  logic pwr_good;
  logic pwr_err;

  modport master (
    output pd_req, wake_req, pwr_good,
    input  save, restore, clk_en, iso_en,
    input  pwr_en, busy, domain_off, pwr_err
  );

  modport slave (
    input  pd_req, wake_req, pwr_good,
    output save, restore, clk_en, iso_en,
    output pwr_en, busy, domain_off, pwr_err
  );
`else
  modport master (
    output pd_req, wake_req,
    input  save, restore, clk_en, iso_en,
    input  pwr_en, busy, domain_off
  );

  modport slave (
    input  pd_req, wake_req,
    output save, restore, clk_en, iso_en,
    output pwr_en, busy, domain_off
  );
`endif
endinterface

// File: rtl/retention_power_sequencer.sv
// Power-down / wake-up sequencer for one retention domain.
// Define RET_PWR_GOOD_EN to gate power-switch settling on pwr_good.
module retention_power_sequencer #(
  parameter int ISO_DLY = 2,
  parameter int PWR_DLY = 4
) (
  input logic                           clk,
  input logic                           rst_n,
  retention_power_sequencer_if.slave    bus
);

  typedef enum logic [3:0] {
    ON, SAVE, CLK_OFF, ISO, PWR_DN,
    OFF, PWR_UP, CLK_ON, RESTORE, DEISO
  } state_t;

  typedef struct packed {
    logic save;
    logic restore;
    logic clk_en;
    logic iso_en;
    logic pwr_en;
    logic busy;
    logic domain_off;
  } out_t;

  localparam out_t OUT_ON = '{
    save: 1'b0, restore: 1'b0, clk_en: 1'b1,
    iso_en: 1'b0, pwr_en: 1'b1, busy: 1'b0,
    domain_off: 1'b0
  };

  localparam logic [7:0] ISO_LAST = 8'(ISO_DLY - 1);
  localparam logic [7:0] PWR_LAST = 8'(PWR_DLY - 1);

  state_t     state;
  state_t     state_d;
  logic [7:0] cnt;
  logic [7:0] cnt_d;
  out_t       out_q;
  out_t       out_d;
  logic       err_set;
  logic       err_q;

  // Count restarts on every state entry
  assign cnt_d = (state_d != state) ? 8'd0 : cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ON;
      cnt   <= 8'd0;
      out_q <= OUT_ON;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      out_q <= out_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    err_set = 1'b0;
    unique case (state)
      ON:      if (bus.pd_req) state_d = SAVE;
      SAVE:    state_d = CLK_OFF;
      CLK_OFF: state_d = ISO;
      ISO:     if (cnt == ISO_LAST) state_d = PWR_DN;
`ifdef RET_PWR_GOOD_EN
      PWR_DN: begin
        if (!bus.pwr_good) begin
          state_d = OFF;
        end else if (cnt == PWR_LAST) begin
          state_d = OFF;
          err_set = 1'b1;
        end
      end
      PWR_UP: begin
        if (bus.pwr_good) begin
          state_d = CLK_ON;
        end else if (cnt == PWR_LAST) begin
          state_d = CLK_ON;
          err_set = 1'b1;
        end
      end
`else
      PWR_DN:  if (cnt == PWR_LAST) state_d = OFF;
      PWR_UP:  if (cnt == PWR_LAST) state_d = CLK_ON;
`endif
      OFF:     if (bus.wake_req) state_d = PWR_UP;
      CLK_ON:  state_d = RESTORE;
      RESTORE: state_d = DEISO;
      DEISO:   if (cnt == ISO_LAST) state_d = ON;
      default: state_d = ON;
    endcase
  end

  // Decode the next state so outputs leave the flops aligned with it
  always_comb begin
    out_d = OUT_ON;
    unique case (state_d)
      ON: ;
      SAVE: begin
        out_d.save = 1'b1;
        out_d.busy = 1'b1;
      end
      CLK_OFF: begin
        out_d.clk_en = 1'b0;
        out_d.busy   = 1'b1;
      end
      ISO: begin
        out_d.clk_en = 1'b0;
        out_d.iso_en = 1'b1;
        out_d.busy   = 1'b1;
      end
      PWR_DN: begin
        out_d.clk_en = 1'b0;
        out_d.iso_en = 1'b1;
        out_d.pwr_en = 1'b0;
        out_d.busy   = 1'b1;
      end
      OFF: begin
        out_d.clk_en     = 1'b0;
        out_d.iso_en     = 1'b1;
        out_d.pwr_en     = 1'b0;
        out_d.domain_off = 1'b1;
      end
      PWR_UP: begin
        out_d.clk_en = 1'b0;
        out_d.iso_en = 1'b1;
        out_d.busy   = 1'b1;
      end
      CLK_ON: begin
        out_d.iso_en = 1'b1;
        out_d.busy   = 1'b1;
      end
      RESTORE: begin
        out_d.iso_en  = 1'b1;
        out_d.restore = 1'b1;
        out_d.busy    = 1'b1;
      end
      DEISO: begin
        out_d.iso_en = 1'b1;
        out_d.busy   = 1'b1;
      end
      default: out_d = OUT_ON;
    endcase
  end

  assign bus.save       = out_q.save;
  assign bus.restore    = out_q.restore;
  assign bus.clk_en     = out_q.clk_en;
  assign bus.iso_en     = out_q.iso_en;
  assign bus.pwr_en     = out_q.pwr_en;
  assign bus.busy       = out_q.busy;
  assign bus.domain_off = out_q.domain_off;

`ifdef RET_PWR_GOOD_EN
  assign bus.pwr_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q ^ err_set;
`endif

endmodule

// File: tb/tb_retention_power_sequencer.sv
// Directed scoreboard bench for retention_power_sequencer.
// Expected output vectors are queued as stimulus is applied.
module tb_retention_power_sequencer;

  logic clk;
  logic rst_n;

  retention_power_sequencer_if bus ();

  retention_power_sequencer #(
    .ISO_DLY (2),
    .PWR_DLY (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RET_PWR_GOOD_EN
  // Switch never reports settled in time: both ramps hit the timeout
  assign bus.pwr_good = ~bus.pwr_en;
`endif

  // {save,restore,clk_en,iso_en,pwr_en,busy,domain_off}
  localparam logic [6:0] V_ON     = 7'b0010100;
  localparam logic [6:0] V_SAVE   = 7'b1010110;
  localparam logic [6:0] V_CLKOFF = 7'b0000110;
  localparam logic [6:0] V_ISO    = 7'b0001110;
  localparam logic [6:0] V_PDN    = 7'b0001010;
  localparam logic [6:0] V_OFF    = 7'b0001001;
  localparam logic [6:0] V_PUP    = 7'b0001110;
  localparam logic [6:0] V_CLKON  = 7'b0011110;
  localparam logic [6:0] V_REST   = 7'b0111110;
  localparam logic [6:0] V_DEISO  = 7'b0011110;

  logic [6:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  logic [31:0] live;
  logic [31:0] ret;
  int n_restore;

  // Retention flop model: contents vanish while unpowered
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 32'hA5A5_1234;
      ret  <= 32'h0;
    end else begin
      if (bus.save) ret <= live;
      if (!bus.pwr_en) live <= 32'hDEAD_BEEF;
      else if (bus.restore) live <= ret;
    end
  end

  initial n_restore = 0;
  always @(posedge clk) if (bus.restore === 1'b1) n_restore <= n_restore + 1;

  function automatic logic [6:0] obs_vec();
    return {bus.save, bus.restore, bus.clk_en, bus.iso_en,
            bus.pwr_en, bus.busy, bus.domain_off};
  endfunction

  task automatic push(logic [6:0] v, int n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(string tag, logic o, logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic compare(string tag);
    logic [6:0] o;
    logic [6:0] e;
    logic inv;
    @(negedge clk);
    o = obs_vec();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%b expected=<empty queue>", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
    end
    inv = !(o[6] && !(o[4] && o[2] && !o[3]))
       && !(o[5] && !(o[4] && o[2] && o[3]))
       && (o[2] || (o[3] && !o[4]));
    check_bit({tag, "_order"}, inv, 1'b1);
  endtask

  initial begin
    int r0;
    rst_n = 1'b0;
    bus.pd_req = 1'b0;
    bus.wake_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    push(V_ON, 10);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      compare("reset");
    end
`ifdef RET_PWR_GOOD_EN
    check_bit("err_reset", bus.pwr_err, 1'b0);
`endif

    push(V_ON, 1); push(V_SAVE, 1); push(V_CLKOFF, 1);
    push(V_ISO, 2); push(V_PDN, 4); push(V_OFF, 3);
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      bus.pd_req = (i == 0);
      compare("pd");
`ifdef RET_PWR_GOOD_EN
      check_bit("pwr_err", bus.pwr_err, i >= 9);
`endif
    end

    push(V_OFF, 1); push(V_PUP, 4); push(V_CLKON, 1);
    push(V_REST, 1); push(V_DEISO, 2); push(V_ON, 3);
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      bus.wake_req = (i == 0);
      compare("wake");
    end
    checks++;
    assert (live === 32'hA5A5_1234) else begin
      errors++;
      $error("FAIL ret_data observed=%h expected=%h",
             live, 32'hA5A5_1234);
    end

    push(V_ON, 1); push(V_SAVE, 1); push(V_CLKOFF, 1);
    push(V_ISO, 2); push(V_PDN, 4); push(V_OFF, 1);
    push(V_PUP, 4); push(V_CLKON, 1); push(V_REST, 1);
    push(V_DEISO, 2); push(V_ON, 2);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      bus.pd_req = (i == 0);
      bus.wake_req = (i == 4) || (i >= 9);
      compare("early_wake");
    end
    bus.wake_req = 1'b0;
    checks++;
    assert (live === 32'hA5A5_1234) else begin
      errors++;
      $error("FAIL ret_data2 observed=%h expected=%h",
             live, 32'hA5A5_1234);
    end

    push(V_ON, 1); push(V_SAVE, 1); push(V_CLKOFF, 1);
    push(V_ISO, 2); push(V_PDN, 1);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      bus.pd_req = (i == 0);
      compare("rst_seq");
    end
    next_cycle();
    r0 = n_restore;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (obs_vec() === V_ON) else begin
      errors++;
      $error("FAIL async_rst observed=%b expected=%b", obs_vec(), V_ON);
    end
`ifdef RET_PWR_GOOD_EN
    check_bit("err_cleared", bus.pwr_err, 1'b0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push(V_ON, 8);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      compare("post_rst");
    end
    checks++;
    assert (n_restore === r0) else begin
      errors++;
      $error("FAIL no_restore observed=%0d expected=%0d", n_restore, r0);
    end

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
